// File: rtl/tt_um_mod6_rr_scheduler.sv
// tt_um_mod6_rr_scheduler
// Round-robin time-slice scheduler. It shares one slice counter between four
// requesters. A winner holds the grant for up to SLICE_LEN cycles, or until it
// drops its request. Every grant is followed by a one-cycle turnaround gap,
// and then priority rotates to the requester after the last holder.
//
// Optional feature: define SCHED_PRIO_EN to let ui_in[6] force requester 0 to
// win at any arbitration point where req[0] is asserted. It never preempts a
// running grant.
//
// Pin map:
//   ui_in   [3:0] req, [4] pause, [5] soft clear, [6] prio0, [7] unused
//   uo_out  [3:0] grant (one-hot), [6:4] slice count, [7] busy
//   uio_out [1:0] holder (current or last), [2] slice_done, [7:3] grant count
//
// Handshake: req[i] is a level request. The scheduler answers with grant[i]
// one cycle after it samples req[i] at an arbitration point. The grant stays
// high while req[i] is held and the slice has not expired. When req[i] drops,
// the grant is released on the next edge. There is no preemption.
module tt_um_mod6_rr_scheduler #(
    parameter int SLICE_LEN = 6,
    parameter int CNT_W     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] SLICE_LAST = CNT_W'(SLICE_LEN - 1);

    logic [3:0] req;
    logic       pause;
    logic       clear;

    assign req   = ui_in[3:0];
    assign pause = ui_in[4];
    assign clear = ui_in[5];

    state_t           state_q, state_d;
    logic [3:0]       grant_q, grant_d;
    logic [CNT_W-1:0] slice_q, slice_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       holder_q, holder_d;
    logic             done_q, done_d;
    logic [4:0]       gcnt_q, gcnt_d;
    logic             busy_q, busy_d;

    logic             win_found;
    logic [1:0]       win_idx;
    logic [1:0]       scan_idx;

    // The unused pins are tied into one reduction so that nothing dangles.
    logic unused_pins;
`ifdef SCHED_PRIO_EN
    assign unused_pins = &{1'b0, uio_in, ena, ui_in[7]};
`else
    assign unused_pins = &{1'b0, uio_in, ena, ui_in[7], ui_in[6]};
`endif

    // Pick the first asserted request starting at ptr, wrapping modulo 4.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        scan_idx  = ptr_q;
        // Scan from the farthest offset down, so the closest match to ptr wins.
        for (int k = 3; k >= 0; k--) begin
            scan_idx = ptr_q + 2'(k);
            if (req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
`ifdef SCHED_PRIO_EN
        if (ui_in[6] && req[0]) begin
            win_found = 1'b1;
            win_idx   = 2'd0;
        end
`endif
    end

    // Next-state logic: clear overrides pause, and pause overrides normal operation.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        slice_d  = slice_q;
        ptr_d    = ptr_q;
        holder_d = holder_q;
        done_d   = 1'b0;
        gcnt_d   = gcnt_q;

        if (clear) begin
            state_d  = IDLE;
            grant_d  = 4'd0;
            slice_d  = '0;
            ptr_d    = 2'd0;
            holder_d = 2'd0;
            gcnt_d   = 5'd0;
        end else if (pause) begin
            // Everything holds its value. slice_d keeps slice_q and done_d stays 0.
        end else begin
            case (state_q)
                GRANT: begin
                    // Expiry takes precedence over a drop on the same edge.
                    if (slice_q == SLICE_LAST || !req[holder_q]) begin
                        done_d  = (slice_q == SLICE_LAST);
                        state_d = GAP;
                        grant_d = 4'd0;
                        slice_d = '0;
                        ptr_d   = holder_q + 2'd1;
                        gcnt_d  = gcnt_q + 5'd1;
                    end else begin
                        slice_d = slice_q + CNT_W'(1);
                    end
                end
                default: begin
                    // IDLE and GAP both arbitrate on this edge.
                    if (win_found) begin
                        state_d  = GRANT;
                        grant_d  = 4'b0001 << win_idx;
                        holder_d = win_idx;
                        slice_d  = '0;
                    end else begin
                        state_d = IDLE;
                        grant_d = 4'd0;
                    end
                end
            endcase
        end
    end

    assign busy_d = (state_d != IDLE);

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= 4'd0;
            slice_q  <= '0;
            ptr_q    <= 2'd0;
            holder_q <= 2'd0;
            done_q   <= 1'b0;
            gcnt_q   <= 5'd0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            slice_q  <= slice_d;
            ptr_q    <= ptr_d;
            holder_q <= holder_d;
            done_q   <= done_d;
            gcnt_q   <= gcnt_d;
            busy_q   <= busy_d;
        end
    end

    assign uo_out  = {busy_q, 3'(slice_q), grant_q};
    assign uio_out = {gcnt_q, done_q, holder_q};
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_mod6_rr_scheduler.sv
// Self-checking bench for tt_um_mod6_rr_scheduler. The reference model keeps
// the owner, the cycles it has used, the rotation start and the grant count
// as plain integers. Each clock edge pushes the model's expected pins onto
// exp_q, and the scenario tasks pop that queue and compare.
module tb_tt_um_mod6_rr_scheduler;

    localparam int SLICE_LEN = 6;

    logic       clk;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       ena;

    int checks;
    int errors;

    logic [15:0] exp_q[$];

    // Reference model state.
    int m_owner;
    int m_used;
    int m_ptr;
    int m_last;
    int m_cnt;
    bit m_gap;
    bit m_done;

    tt_um_mod6_rr_scheduler #(.SLICE_LEN(SLICE_LEN), .CNT_W(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = -1;
        m_used  = 0;
        m_ptr   = 0;
        m_last  = 0;
        m_cnt   = 0;
        m_gap   = 0;
        m_done  = 0;
    endtask

    task automatic model_step(input logic [7:0] ui);
        logic [3:0] req;
        int w;
        req = ui[3:0];
        if (ui[5]) begin
            model_reset();
        end else if (ui[4]) begin
            m_done = 0;
        end else if (m_owner >= 0) begin
            if (m_used == SLICE_LEN - 1 || !req[m_owner]) begin
                m_done  = (m_used == SLICE_LEN - 1);
                m_ptr   = (m_owner + 1) % 4;
                m_cnt   = (m_cnt + 1) % 32;
                m_owner = -1;
                m_used  = 0;
                m_gap   = 1;
            end else begin
                m_used = m_used + 1;
                m_done = 0;
            end
        end else begin
            m_done = 0;
            m_gap  = 0;
            w = -1;
            for (int k = 0; k < 4; k++)
                if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
`ifdef SCHED_PRIO_EN
            if (ui[6] && req[0]) w = 0;
`endif
            if (w >= 0) begin
                m_owner = w;
                m_last  = w;
                m_used  = 0;
            end
        end
    endtask

    function automatic logic [15:0] model_out();
        logic [3:0] g;
        logic [7:0] uo;
        logic [7:0] uio;
        g   = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
        uo  = {(m_owner >= 0 || m_gap) ? 1'b1 : 1'b0, 3'(m_used), g};
        uio = {5'(m_cnt), m_done, 2'(m_last)};
        return {uo, uio};
    endfunction

    // Driver: apply ui, let one edge pass, advance the model, and settle at negedge.
    task automatic tick(input logic [7:0] ui);
        ui_in = ui;
        @(posedge clk);
        model_step(ui);
        exp_q.push_back(model_out());
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [15:0] exp_v;
        for (int i = 0; i < 4; i++) begin
            tick(8'h01);
            exp_v = exp_q.pop_front();
            checks++;
            if ({uo_out, uio_out} !== exp_v) begin
                errors++;
                $display("FAIL reset_lead cyc%0d got %h exp %h", i, {uo_out, uio_out}, exp_v);
            end
        end
        checks++;
        if (uo_out[6:4] !== 3'd3) begin
            errors++;
            $display("FAIL reset_slice3 got %0d exp 3", uo_out[6:4]);
        end
        // Reset asserts between edges, so the outputs must clear without a clock edge.
        rst_n = 1'b0;
        #1;
        checks++;
        if (uo_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_uo got %h exp 00", uo_out);
        end
        checks++;
        if (uio_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_uio got %h exp 00", uio_out);
        end
        checks++;
        if (uio_oe !== 8'hFF) begin
            errors++;
            $display("FAIL reset_oe got %h exp ff", uio_oe);
        end
        ui_in = 8'h00;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        exp_q.delete();
    endtask

    task automatic test_single();
        logic [15:0] exp_v;
        tick(8'h20);
        void'(exp_q.pop_front());
        for (int i = 1; i <= 16; i++) begin
            tick(8'h04);
            exp_v = exp_q.pop_front();
            checks++;
            if ({uo_out, uio_out} !== exp_v) begin
                errors++;
                $display("FAIL single cyc%0d got %h exp %h", i, {uo_out, uio_out}, exp_v);
            end
            if (i == 7 || i == 14) begin
                checks++;
                if (uio_out[7:2] !== {5'(i / 7), 1'b1} || uo_out[3:0] !== 4'd0) begin
                    errors++;
                    $display("FAIL single_gap cyc%0d got uio %h uo %h exp cnt %0d done 1", i, uio_out, uo_out, i / 7);
                end
            end
        end
    endtask

    task automatic test_rotation();
        logic [15:0] exp_v;
        tick(8'h20);
        void'(exp_q.pop_front());
        for (int i = 1; i <= 29; i++) begin
            tick(8'h0F);
            exp_v = exp_q.pop_front();
            checks++;
            if ({uo_out, uio_out} !== exp_v) begin
                errors++;
                $display("FAIL rotation cyc%0d got %h exp %h", i, {uo_out, uio_out}, exp_v);
            end
            if ((i % 7) == 1) begin
                checks++;
                if (uo_out[3:0] !== 4'(1 << ((i / 7) % 4))) begin
                    errors++;
                    $display("FAIL rotation_order cyc%0d got %b exp %b", i, uo_out[3:0], 4'(1 << ((i / 7) % 4)));
                end
            end
        end
    endtask

    task automatic test_early_drop();
        logic [15:0] exp_v;
        logic [7:0] stim [6];
        stim = '{8'h20, 8'h01, 8'h01, 8'h01, 8'h02, 8'h02};
        for (int i = 0; i < 6; i++) begin
            tick(stim[i]);
            exp_v = exp_q.pop_front();
            checks++;
            if ({uo_out, uio_out} !== exp_v) begin
                errors++;
                $display("FAIL early_drop cyc%0d got %h exp %h", i, {uo_out, uio_out}, exp_v);
            end
        end
        checks++;
        if (uo_out[3:0] !== 4'b0010) begin
            errors++;
            $display("FAIL early_drop_next got %b exp 0010", uo_out[3:0]);
        end
    endtask

    task automatic test_pause_clear();
        logic [15:0] exp_v;
        logic [7:0] stim [14];
        stim = '{8'h20, 8'h04, 8'h04, 8'h04, 8'h04, 8'h14, 8'h14, 8'h14, 8'h14,
                 8'h04, 8'h04, 8'h04, 8'h34, 8'h0F};
        for (int i = 0; i < 14; i++) begin
            tick(stim[i]);
            exp_v = exp_q.pop_front();
            checks++;
            if ({uo_out, uio_out} !== exp_v) begin
                errors++;
                $display("FAIL pause_clear cyc%0d got %h exp %h", i, {uo_out, uio_out}, exp_v);
            end
            if (i >= 5 && i <= 8) begin
                checks++;
                if (uo_out !== 8'hB4 || uio_out[2] !== 1'b0) begin
                    errors++;
                    $display("FAIL pause_hold cyc%0d got uo %h exp b4", i, uo_out);
                end
            end
            if (i == 11) begin
                checks++;
                if (uio_out[2] !== 1'b1) begin
                    errors++;
                    $display("FAIL pause_expiry got done %b exp 1", uio_out[2]);
                end
            end
            if (i == 12) begin
                checks++;
                if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
                    errors++;
                    $display("FAIL clear_over_pause got uo %h uio %h exp 00 00", uo_out, uio_out);
                end
            end
            if (i == 13) begin
                checks++;
                if (uo_out[3:0] !== 4'b0001) begin
                    errors++;
                    $display("FAIL clear_ptr got %b exp 0001", uo_out[3:0]);
                end
            end
        end
    endtask

`ifdef SCHED_PRIO_EN
    task automatic test_prio();
        logic [15:0] exp_v;
        logic [7:0] stim [5];
        // Requester 1 is granted and then drops, which leaves ptr=2. Prio0 then wins from the gap.
        stim = '{8'h20, 8'h02, 8'h00, 8'h45, 8'h00};
        for (int i = 0; i < 5; i++) begin
            tick(stim[i]);
            exp_v = exp_q.pop_front();
            checks++;
            if ({uo_out, uio_out} !== exp_v) begin
                errors++;
                $display("FAIL prio cyc%0d got %h exp %h", i, {uo_out, uio_out}, exp_v);
            end
            if (i == 3) begin
                checks++;
                if (uo_out[3:0] !== 4'b0001) begin
                    errors++;
                    $display("FAIL prio_win got %b exp 0001", uo_out[3:0]);
                end
            end
        end
        // ptr is now 1, so with all requests up requester 1 wins next.
        tick(8'h0F);
        exp_v = exp_q.pop_front();
        checks++;
        if ({uo_out, uio_out} !== exp_v || uo_out[3:0] !== 4'b0010) begin
            errors++;
            $display("FAIL prio_ptr got %h exp %h", {uo_out, uio_out}, exp_v);
        end
    endtask
`endif

    task automatic test_random();
        logic [15:0] exp_v;
        logic [7:0]  ui;
        logic [3:0]  req;
        req = 4'd0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            ui = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0, req};
            tick(ui);
            exp_v = exp_q.pop_front();
            checks++;
            if ({uo_out, uio_out} !== exp_v) begin
                errors++;
                $display("FAIL random cyc%0d ui %h got %h exp %h", i, ui, {uo_out, uio_out}, exp_v);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        ena    = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        test_reset();
        test_single();
        test_rotation();
        test_early_drop();
        test_pause_clear();
`ifdef SCHED_PRIO_EN
        test_prio();
`endif
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
